// File: rtl/cbd_interval_timer.sv
// Programmable interval timer: prescaled down-counter with auto-reload,
// one-cycle CAO expiry pulse and sticky terminal-count flag.
module cbd_interval_timer #(
  parameter int WIDTH = 8,
  parameter int PSC_W = 4
) (
  input  logic             CLK,
  input  logic             CDN,
  input  logic [WIDTH-1:0] D,
  input  logic             LD,
  input  logic             START,
  input  logic             STOP,
  input  logic             PERIODIC,
  input  logic [PSC_W-1:0] PSC,
  input  logic             CAI,
  input  logic             TCF_CLR,
  output logic [WIDTH-1:0] Q,
  output logic             CAO,
  output logic             BUSY,
  output logic             TCF
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] reload, reload_nx, q_nx;
  logic [PSC_W-1:0] pre, pre_nx;
  logic             ctrl, tick, expire;

  // LD/STOP/START all pre-empt the tick, so an expiry on such an edge is lost.
  assign ctrl   = LD | STOP | START;
  assign tick   = (state == S_RUN) & CAI & (pre >= PSC);
  assign expire = ~ctrl & tick & (Q == '0);
  assign BUSY   = (state == S_RUN);

  always_comb begin
    state_nx  = state;
    reload_nx = reload;
    q_nx      = Q;
    pre_nx    = pre;
    if (STOP)       state_nx = S_IDLE;
    else if (START) state_nx = S_RUN;
    if (LD) begin
      reload_nx = D;
      q_nx      = D;
      pre_nx    = '0;
    end else if (STOP) begin
      pre_nx = '0;
    end else if (START) begin
      q_nx   = reload;
      pre_nx = '0;
    end else if (state == S_RUN && CAI) begin
      if (tick) begin
        pre_nx = '0;
        if (Q != '0)    q_nx = Q - WIDTH'(1);
        else if (PERIODIC) q_nx = reload;
        else            state_nx = S_DONE;
      end else begin
        pre_nx = pre + PSC_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge CDN) begin
    if (!CDN) begin
      state  <= S_IDLE;
      reload <= '0;
      Q      <= '0;
      pre    <= '0;
      CAO    <= 1'b0;
      TCF    <= 1'b0;
    end else begin
      state  <= state_nx;
      reload <= reload_nx;
      Q      <= q_nx;
      pre    <= pre_nx;
      CAO    <= expire;
      TCF    <= expire | (TCF & ~TCF_CLR);
    end
  end

endmodule

// File: tb/tb_cbd_interval_timer.sv
// Self-checking bench for cbd_interval_timer: per-scenario tables feed a
// scoreboard queue of expected {Q,CAO,BUSY,TCF} popped after each edge.
module tb_cbd_interval_timer;

  logic       CLK, CDN, LD, START, STOP, PERIODIC, CAI, TCF_CLR;
  logic [7:0] D, Q;
  logic [3:0] PSC;
  logic       CAO, BUSY, TCF;

  int errors = 0;
  int checks = 0;
  logic [10:0] sb[$];

  cbd_interval_timer #(.WIDTH(8), .PSC_W(4)) dut (
    .CLK(CLK), .CDN(CDN), .D(D), .LD(LD), .START(START), .STOP(STOP),
    .PERIODIC(PERIODIC), .PSC(PSC), .CAI(CAI), .TCF_CLR(TCF_CLR),
    .Q(Q), .CAO(CAO), .BUSY(BUSY), .TCF(TCF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  // Stimulus word: {per, psc[3:0], d[7:0], ld, start, stop, clr, cai}
  function automatic logic [17:0] S(bit ld, bit st, bit sp, bit clr, bit cai,
                                    logic [7:0] d, logic [3:0] psc, bit per);
    return {per, psc, d, ld, st, sp, clr, cai};
  endfunction

  function automatic logic [10:0] X(logic [7:0] q, bit cao, bit busy, bit tcf);
    return {q, cao, busy, tcf};
  endfunction

  task automatic drive(logic [17:0] w);
    {PERIODIC, PSC, D, LD, START, STOP, TCF_CLR, CAI} = w;
  endtask

  task automatic test_reset;
    logic [10:0] e;
    CDN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(18'($urandom));
      @(posedge CLK); #1;
      checks++;
      if ({Q, CAO, BUSY, TCF} !== 11'd0) begin
        errors++;
        $display("FAIL reset_hold[%0d] got q=%0d cao=%b busy=%b tcf=%b want all 0",
                 i, Q, CAO, BUSY, TCF);
      end
    end
    drive(S(0,0,0,0,1, 8'd0, 4'd0, 1));
    CDN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sb.push_back(X(8'd0,0,0,0));
      @(posedge CLK); #1;
      e = sb.pop_front();
      checks++;
      if ({Q, CAO, BUSY, TCF} !== e) begin
        errors++;
        $display("FAIL reset_idle[%0d] got q=%0d cao=%b busy=%b tcf=%b want q=%0d cao=%b busy=%b tcf=%b",
                 i, Q, CAO, BUSY, TCF, e[10:3], e[2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_periodic;
    logic [17:0] w[13];
    logic [10:0] x[13];
    logic [10:0] e;
    w = '{S(1,0,0,0,1,3,0,1), S(0,1,0,0,1,3,0,1), S(0,0,0,0,1,3,0,1), S(0,0,0,0,1,3,0,1),
          S(0,0,0,0,1,3,0,1), S(0,0,0,0,1,3,0,1), S(0,0,0,0,1,3,0,1), S(0,0,0,0,1,3,0,1),
          S(0,0,0,0,1,3,0,1), S(0,0,0,0,1,3,0,1), S(0,0,0,0,1,3,0,1), S(0,0,1,0,1,3,0,1),
          S(0,0,0,1,1,3,0,1)};
    x = '{X(3,0,0,0), X(3,0,1,0), X(2,0,1,0), X(1,0,1,0), X(0,0,1,0), X(3,1,1,1),
          X(2,0,1,1), X(1,0,1,1), X(0,0,1,1), X(3,1,1,1), X(2,0,1,1), X(2,0,0,1),
          X(2,0,0,0)};
    for (int i = 0; i < 13; i++) begin
      drive(w[i]);
      sb.push_back(x[i]);
      @(posedge CLK); #1;
      e = sb.pop_front();
      checks++;
      if ({Q, CAO, BUSY, TCF} !== e) begin
        errors++;
        $display("FAIL periodic[%0d] got q=%0d cao=%b busy=%b tcf=%b want q=%0d cao=%b busy=%b tcf=%b",
                 i, Q, CAO, BUSY, TCF, e[10:3], e[2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_oneshot;
    logic [17:0] w[17];
    logic [10:0] x[17];
    logic [10:0] e;
    for (int i = 0; i < 17; i++) w[i] = S(0,0,0,0,1,2,2,0);
    w[0]  = S(1,0,0,0,1,2,2,0);
    w[1]  = S(0,1,0,0,1,2,2,0);
    w[13] = S(0,1,0,0,1,2,2,0);
    w[15] = S(0,0,1,0,1,2,2,0);
    w[16] = S(0,0,0,1,1,2,2,0);
    x = '{X(2,0,0,0), X(2,0,1,0), X(2,0,1,0), X(2,0,1,0), X(1,0,1,0), X(1,0,1,0),
          X(1,0,1,0), X(0,0,1,0), X(0,0,1,0), X(0,0,1,0), X(0,1,0,1), X(0,0,0,1),
          X(0,0,0,1), X(2,0,1,1), X(2,0,1,1), X(2,0,0,1), X(2,0,0,0)};
    for (int i = 0; i < 17; i++) begin
      drive(w[i]);
      sb.push_back(x[i]);
      @(posedge CLK); #1;
      e = sb.pop_front();
      checks++;
      if ({Q, CAO, BUSY, TCF} !== e) begin
        errors++;
        $display("FAIL oneshot[%0d] got q=%0d cao=%b busy=%b tcf=%b want q=%0d cao=%b busy=%b tcf=%b",
                 i, Q, CAO, BUSY, TCF, e[10:3], e[2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_cai_gating;
    logic [17:0] w[16];
    logic [10:0] x[16];
    logic [10:0] e;
    w[0] = S(1,0,0,0,1,2,1,1);
    w[1] = S(0,1,0,0,1,2,1,1);
    for (int i = 2; i < 14; i++) w[i] = S(0,0,0,0,bit'((i - 1) % 2),2,1,1);
    w[14] = S(0,0,1,0,0,2,1,1);
    w[15] = S(0,0,0,1,0,2,1,1);
    x = '{X(2,0,0,0), X(2,0,1,0), X(2,0,1,0), X(2,0,1,0), X(1,0,1,0), X(1,0,1,0),
          X(1,0,1,0), X(1,0,1,0), X(0,0,1,0), X(0,0,1,0), X(0,0,1,0), X(0,0,1,0),
          X(2,1,1,1), X(2,0,1,1), X(2,0,0,1), X(2,0,0,0)};
    for (int i = 0; i < 16; i++) begin
      drive(w[i]);
      sb.push_back(x[i]);
      @(posedge CLK); #1;
      e = sb.pop_front();
      checks++;
      if ({Q, CAO, BUSY, TCF} !== e) begin
        errors++;
        $display("FAIL cai_gating[%0d] got q=%0d cao=%b busy=%b tcf=%b want q=%0d cao=%b busy=%b tcf=%b",
                 i, Q, CAO, BUSY, TCF, e[10:3], e[2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_priority;
    logic [17:0] w[23];
    logic [10:0] x[23];
    logic [10:0] e;
    w = '{S(1,1,0,0,1,5,0,1), S(0,0,1,0,1,5,0,1),
          S(1,0,0,0,1,1,0,1), S(0,1,0,0,1,1,0,1), S(0,0,0,0,1,1,0,1), S(0,0,1,0,1,1,0,1),
          S(0,0,0,0,1,1,0,1), S(0,1,0,0,1,1,0,1), S(0,0,0,0,1,1,0,1), S(0,0,0,1,1,1,0,1),
          S(0,0,0,1,1,1,0,1), S(0,0,1,0,1,1,0,1),
          S(1,0,0,0,1,3,7,1), S(0,1,0,0,1,3,7,1), S(0,0,0,0,1,3,7,1), S(0,0,0,0,1,3,7,1),
          S(0,0,0,0,1,3,7,1), S(0,0,0,0,1,3,7,1), S(0,0,0,0,1,3,7,1), S(0,0,0,0,1,3,1,1),
          S(0,0,0,0,1,3,1,1), S(0,0,0,0,1,3,1,1), S(0,0,1,0,1,3,1,1)};
    x = '{X(5,0,1,0), X(5,0,0,0),
          X(1,0,0,0), X(1,0,1,0), X(0,0,1,0), X(0,0,0,0), X(0,0,0,0), X(1,0,1,0),
          X(0,0,1,0), X(1,1,1,1), X(0,0,1,0), X(0,0,0,0),
          X(3,0,0,0), X(3,0,1,0), X(3,0,1,0), X(3,0,1,0), X(3,0,1,0), X(3,0,1,0),
          X(3,0,1,0), X(2,0,1,0), X(2,0,1,0), X(1,0,1,0), X(1,0,0,0)};
    for (int i = 0; i < 23; i++) begin
      drive(w[i]);
      sb.push_back(x[i]);
      @(posedge CLK); #1;
      e = sb.pop_front();
      checks++;
      if ({Q, CAO, BUSY, TCF} !== e) begin
        errors++;
        $display("FAIL priority[%0d] got q=%0d cao=%b busy=%b tcf=%b want q=%0d cao=%b busy=%b tcf=%b",
                 i, Q, CAO, BUSY, TCF, e[10:3], e[2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_async_reset;
    logic [17:0] w[9];
    logic [10:0] x[9];
    logic [10:0] e;
    w = '{S(1,0,0,0,1,7,0,1), S(0,1,0,0,1,7,0,1), S(0,0,0,0,1,7,0,1), S(0,0,0,0,1,7,0,1),
          S(0,0,0,0,1,7,0,1), S(0,1,0,0,1,7,0,1), S(0,0,0,0,1,7,0,1), S(0,0,0,0,1,7,0,1),
          S(0,0,1,0,1,7,0,1)};
    // entries 4.. follow the mid-count clear: reload is back to 0
    x = '{X(7,0,0,0), X(7,0,1,0), X(6,0,1,0), X(5,0,1,0), X(0,0,0,0), X(0,0,1,0),
          X(0,1,1,1), X(0,1,1,1), X(0,0,0,1)};
    for (int i = 0; i < 9; i++) begin
      if (i == 4) begin
        #2 CDN = 1'b0;
        #1;
        checks++;
        if ({Q, CAO, BUSY, TCF} !== 11'd0) begin
          errors++;
          $display("FAIL async_clear got q=%0d cao=%b busy=%b tcf=%b want all 0",
                   Q, CAO, BUSY, TCF);
        end
        #2 CDN = 1'b1;
      end
      drive(w[i]);
      sb.push_back(x[i]);
      @(posedge CLK); #1;
      e = sb.pop_front();
      checks++;
      if ({Q, CAO, BUSY, TCF} !== e) begin
        errors++;
        $display("FAIL async_reset[%0d] got q=%0d cao=%b busy=%b tcf=%b want q=%0d cao=%b busy=%b tcf=%b",
                 i, Q, CAO, BUSY, TCF, e[10:3], e[2], e[1], e[0]);
      end
    end
  endtask

  initial begin
    CDN = 1'b0;
    drive(18'd0);
    test_reset();
    test_periodic();
    test_oneshot();
    test_cai_gating();
    test_priority();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cbd_interval_timer.md
# cbd_interval_timer

Programmable interval timer built around a WIDTH-bit down-count chain with prescaler, auto-reload and terminal-count flagging. It sits directly upstream of cascaded down-counter cells and their consumers. It generates the gated count ticks (the CAI-style enable) and the reload/terminal-count sequencing that a bare 1-bit down-counter cell chain lacks. The block exports a one-cycle CAO pulse per expiry so further stages can cascade off it.

## Interface
- WIDTH, 8, counter and reload width (≥1)
- PSC_W, 4, prescaler divisor width (≥1)

- CLK  in  1  rising-edge clock
- CDN  in  1  asynchronous active-low clear; one clock; reset is asynchronous and active-low
- D  in  WIDTH  reload value
- LD  in  1  synchronous load of D
- START  in  1  start/restart count
- STOP  in  1  halt count
- PERIODIC  in  1  1 = auto-reload, 0 = one-shot
- PSC  in  PSC_W  prescale divisor; tick every PSC+1 enabled cycles
- CAI  in  1  external count enable, gates prescaler
- TCF_CLR  in  1  clear sticky terminal-count flag
- Q  out  WIDTH  current count
- CAO  out  1  registered one-cycle terminal-count pulse
- BUSY  out  1  high in RUN
- TCF  out  1  sticky terminal-count flag

## Operation
- Reset (CDN=0, async): Q=0, reload register=0, prescaler=0, state IDLE, CAO=0, BUSY=0, TCF=0.
- States are IDLE, RUN and DONE. BUSY = (state==RUN).
- Per-edge priority: LD > STOP > START > tick.
  - LD: reload<=D, Q<=D, prescaler<=0; state unchanged.
  - STOP: state<=IDLE, prescaler<=0, Q holds. No effect outside RUN other than the prescaler clear.
  - START from any state: state<=RUN, Q<=reload, prescaler<=0. START in RUN is a restart.
- Prescaler runs only in RUN with CAI=1.
  - tick = RUN & CAI & (prescaler >= PSC). The `>=` covers PSC lowered mid-count.
  - On tick, prescaler<=0; otherwise prescaler+1. CAI=0 holds the prescaler.
- On tick with Q≠0: Q<=Q-1.
- On tick with Q==0 (expiry):
  - CAO<=1 for exactly one cycle and TCF<=1.
  - If PERIODIC=1: Q<=reload and stay in RUN.
  - If PERIODIC=0: state<=DONE and Q stays 0.
- CAO is 0 on all other cycles. An expiry suppressed by same-edge LD/STOP/START produces no CAO.
- TCF clears on TCF_CLR. A set on the same edge wins over the clear.
- PERIODIC is sampled at the expiry edge. PSC is sampled every cycle.
- Arithmetic: Q decrements unsigned and never wraps; the 0 case always takes the expiry path. The prescaler compare is unsigned PSC_W-bit.

## Timing
- All outputs are registered; no combinational input→output paths.
- START at edge k: after edge k, BUSY=1 and Q=reload.
- With PSC=0, CAI=1 and reload R:
  - Q decrements at edges k+1…k+R.
  - Expiry occurs at edge k+R+1, so CAO is high in cycle k+R+1.
  - Period is (R+1)·(PSC+1) enabled cycles.
  - R=0, PSC=0, periodic gives CAO high every cycle.
- CAI low stretches the period cycle-for-cycle and inserts no extra latency.
- CDN asserted mid-count returns all state to reset values immediately. The first edge after deassertion behaves as from IDLE.

## Test plan
- Reset: CDN low with random inputs -> Q=0, CAO=0, BUSY=0, TCF=0; after release, no CAO without START.
- Periodic: LD D=3, PSC=0, CAI=1, PERIODIC=1, START -> Q sequence 3,2,1,0,3; CAO pulse every 4 cycles; TCF=1 after the first pulse.
- One-shot with prescale: D=2, PSC=2, PERIODIC=0 -> expiry 9 cycles after START, single CAO, BUSY drops, Q stays 0 in DONE; re-START reloads 2.
- CAI gating: PSC=1, CAI toggled 1-0-1-0 -> each tick needs 2 CAI-high cycles; period doubles in wall-clock cycles.
- Priority and collisions: LD plus START on the same edge -> Q=D, RUN entered. STOP on an expiry edge -> no CAO, IDLE. TCF_CLR on an expiry edge -> TCF stays 1. PSC lowered from 7 to 1 while prescaler=5 -> tick on the next enabled edge.
- Async reset mid-run: CDN pulsed low between edges at Q=5 -> Q=0 and BUSY=0 at once, without waiting for an edge.
